calc_op_sched: RTL and testbench

//  Sequencer for the calculator arithmetic datapath. Accepts one signed operation
//  (add/sub/mul/div) per start/done handshake from the keypad operand-entry logic.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/muldiv_iter_core.sv | 87 ++++++++
 rtl/calc_op_sched.sv | 180 ++++++++++++++++++
 tb/tb_calc_op_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator arithmetic sequencer: opcodes, FSM states
// and the default datapath width.
package calc_pkg;

  localparam int DEF_WIDTH = 11;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative magnitude unit: shift-add multiply or restoring divide,
// one bit per step, WIDTH steps per operation.
module muldiv_iter_core #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH:0]   mag_a,
  input  logic [WIDTH:0]   mag_b,
  output logic [2*WIDTH:0] prod,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;

  logic [WIDTH+1:0] add_sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Multiply: acc:sreg shifts right, multiplier bits consumed from sreg LSB.
  assign add_sum = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, dvs_q} : '0);
  // Divide: partial remainder takes the next dividend bit from the sreg MSB.
  assign shifted = {acc_q, sreg_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    acc_d  = acc_q;
    dvs_d  = dvs_q;
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    if (load) begin
      acc_d  = '0;
      div_d  = is_div;
      dvs_d  = is_div ? mag_b : mag_a;
      sreg_d = is_div ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0];
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        if (!trial[WIDTH+1]) begin
          acc_d  = trial[WIDTH:0];
          sreg_d = {sreg_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d  = shifted[WIDTH:0];
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d  = add_sum[WIDTH+1:1];
        sreg_d = {add_sum[0], sreg_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      dvs_q  <= '0;
      sreg_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dvs_q  <= dvs_d;
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
    end
  end

  assign prod = {acc_q, sreg_q};
  assign quot = sreg_q;
  assign rem  = acc_q[WIDTH-1:0];
  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/calc_op_sched.sv
// Calculator operation sequencer: single-cycle ADD/SUB, shared iterative unit for
// signed MUL/DIV, registered result/remainder/flags held until the next DONE.
module calc_op_sched
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             overflow,
  output logic             err_div0
);

  localparam int PW = 2 * WIDTH + 1;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_a_q, neg_a_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             overflow_q, overflow_d;
  logic             err_div0_q, err_div0_d;

  logic             core_load, core_step, core_last;
  logic [WIDTH:0]   a_ext, b_ext, abs_a, abs_b;
  logic [PW-1:0]    core_prod;
  logic [WIDTH-1:0] core_quot, core_rem;

  logic [WIDTH:0]   sum_w, diff_w;
  logic [PW:0]      prod_s;
  logic [WIDTH:0]   quot_s;
  logic [WIDTH-1:0] rem_s;
  logic             mul_ovf;

  // One extra bit so that the magnitude of the most negative operand is exact.
  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = {b[WIDTH-1], b};
  assign abs_a = a[WIDTH-1] ? -a_ext : a_ext;
  assign abs_b = b[WIDTH-1] ? -b_ext : b_ext;

  assign sum_w  = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
  assign diff_w = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};

  assign prod_s  = neg_res_q ? -{1'b0, core_prod} : {1'b0, core_prod};
  assign mul_ovf = (prod_s[PW:WIDTH-1] != '0) && (prod_s[PW:WIDTH-1] != '1);
  assign quot_s  = neg_res_q ? -{1'b0, core_quot} : {1'b0, core_quot};
  assign rem_s   = neg_a_q ? -core_rem : core_rem;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (core_load),
    .step   (core_step),
    .is_div (op == OP_DIV),
    .mag_a  (abs_a),
    .mag_b  (abs_b),
    .prod   (core_prod),
    .quot   (core_quot),
    .rem    (core_rem),
    .last   (core_last)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    neg_res_d   = neg_res_q;
    neg_a_d     = neg_a_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    err_div0_d  = err_div0_q;
    core_load   = 1'b0;
    core_step   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          a_d       = a;
          b_d       = b;
          neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_a_d   = a[WIDTH-1];
          if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
            core_load = 1'b1;
            state_d   = S_ITER;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state_d     = S_DONE;
        result_d    = '0;
        remainder_d = '0;
        overflow_d  = 1'b0;
        err_div0_d  = 1'b0;
        case (op_q)
          OP_ADD: begin
            result_d   = sum_w[WIDTH-1:0];
            overflow_d = sum_w[WIDTH] ^ sum_w[WIDTH-1];
          end
          OP_SUB: begin
            result_d   = diff_w[WIDTH-1:0];
            overflow_d = diff_w[WIDTH] ^ diff_w[WIDTH-1];
          end
          OP_DIV: begin
            remainder_d = a_q;
            err_div0_d  = 1'b1;
          end
          default: ;
        endcase
      end
      S_ITER: begin
        core_step = 1'b1;
        if (core_last) state_d = S_FIX;
      end
      S_FIX: begin
        state_d    = S_DONE;
        err_div0_d = 1'b0;
        if (op_q == OP_DIV) begin
          // Only -min/-1 can push the quotient out of range.
          result_d    = quot_s[WIDTH-1:0];
          remainder_d = rem_s;
          overflow_d  = quot_s[WIDTH] ^ quot_s[WIDTH-1];
        end else begin
          result_d    = prod_s[WIDTH-1:0];
          remainder_d = '0;
          overflow_d  = mul_ovf;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      neg_res_q   <= 1'b0;
      neg_a_q     <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      err_div0_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      neg_res_q   <= neg_res_d;
      neg_a_q     <= neg_a_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      err_div0_q  <= err_div0_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign remainder = remainder_q;
  assign overflow  = overflow_q;
  assign err_div0  = err_div0_q;

endmodule

// File: tb/tb_calc_op_sched.sv
// Directed bench for calc_op_sched: integer-arithmetic reference model checked every
// cycle, plus hand-computed literal expectations per operation.
module tb_calc_op_sched;
  import calc_pkg::*;

  localparam int W = 11;
  localparam int MAXV = 2 ** (W - 1) - 1;
  localparam int MINV = -(2 ** (W - 1));

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, done, overflow, err_div0;
  logic [W-1:0] result, remainder;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  typedef struct {
    int r;
    int rem;
    int ovf;
    int err;
    int lat;
  } exp_t;

  exp_t pend, held;
  int   m_phase = 0;
  int   m_left = 0;

  calc_op_sched #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .remainder (remainder),
    .overflow  (overflow),
    .err_div0  (err_div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wrap(input int v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return int'($signed(t));
  endfunction

  // Reference: plain integer arithmetic; SV '/' and '%' truncate toward zero.
  function automatic exp_t model_calc(input int o, input int x, input int y);
    exp_t e;
    int t;
    e = '{r: 0, rem: 0, ovf: 0, err: 0, lat: 2};
    t = 0;
    case (o)
      0: t = x + y;
      1: t = x - y;
      2: begin t = x * y; e.lat = W + 2; end
      default: begin
        if (y == 0) begin
          e.err = 1;
          e.rem = x;
        end else begin
          t = x / y;
          e.rem = x % y;
          e.lat = W + 2;
        end
      end
    endcase
    if (e.err == 0) begin
      e.r = wrap(t);
      e.ovf = (t > MAXV || t < MINV) ? 1 : 0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      held    <= '{default: 0};
    end else begin
      case (m_phase)
        0: if (start) begin
          pend    <= model_calc(int'(op), int'($signed(a)), int'($signed(b)));
          m_left  <= model_calc(int'(op), int'($signed(a)), int'($signed(b))).lat - 1;
          m_phase <= 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2;
            held    <= pend;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready, m_phase == 0);
      chk("done", done, m_phase == 2);
      chk("result", $signed(result), held.r);
      chk("remainder", $signed(remainder), held.rem);
      chk("overflow", overflow, held.ovf);
      chk("err_div0", err_div0, held.err);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic do_op(input string nm, input logic [1:0] o, input int x, input int y,
                       input int er, input int erem, input int eovf, input int eerr,
                       input int elat);
    int cyc;
    start = 1'b1;
    op = o;
    a = x[W-1:0];
    b = y[W-1:0];
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    a = W'($urandom);
    b = W'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, ".latency"}, cyc, elat);
    chk({nm, ".result"}, $signed(result), er);
    chk({nm, ".remainder"}, $signed(remainder), erem);
    chk({nm, ".overflow"}, overflow, eovf);
    chk({nm, ".err_div0"}, err_div0, eerr);
    @(negedge clk);
    chk({nm, ".ready_after"}, ready, 1);
  endtask

  initial begin
    int cyc;
    int dones;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset.ready", ready, 1);
    chk("reset.done", done, 0);
    chk("reset.result", result, 0);
    chk("reset.remainder", remainder, 0);
    chk("reset.flags", {overflow, err_div0}, 0);

    do_op("add_25_m7",   OP_ADD,    25,   -7,    18,    0, 0, 0,  2);
    do_op("add_ovf",     OP_ADD,  1000,  100,  -948,    0, 1, 0,  2);
    do_op("sub_ovf",     OP_SUB, -1024,    1,  1023,    0, 1, 0,  2);
    do_op("sub_5_9",     OP_SUB,     5,    9,    -4,    0, 0, 0,  2);
    do_op("mul_37_m12",  OP_MUL,    37,  -12,  -444,    0, 0, 0, 13);
    do_op("mul_ovf",     OP_MUL,   100,  100,  -240,    0, 1, 0, 13);
    do_op("mul_min_1",   OP_MUL, -1024,    1, -1024,    0, 0, 0, 13);
    do_op("mul_min_m1",  OP_MUL, -1024,   -1, -1024,    0, 1, 0, 13);
    do_op("div_m100_7",  OP_DIV,  -100,    7,   -14,   -2, 0, 0, 13);
    do_op("div0",        OP_DIV,     5,    0,     0,    5, 0, 1,  2);
    do_op("div_min_m1",  OP_DIV, -1024,   -1, -1024,    0, 1, 0, 13);
    do_op("div_7_m2",    OP_DIV,     7,   -2,    -3,    1, 0, 0, 13);
    do_op("div_1023_min", OP_DIV, 1023, -1024,    0, 1023, 0, 0, 13);

    // start held high through a whole MUL: one accept, one done, next op after DONE
    start = 1'b1;
    op = OP_MUL;
    a = W'(-5);
    b = W'(6);
    cyc = 0;
    dones = 0;
    while (dones == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      op = OP_ADD;
      a = W'($urandom);
      b = W'($urandom);
      if (done === 1'b1) dones++;
    end
    chk("pulse.latency", cyc, 13);
    chk("pulse.result", $signed(result), -30);
    a = W'(20);
    b = W'(22);
    @(negedge clk);
    chk("pulse.ready_after_done", ready, 1);
    chk("pulse.no_second_done", done, 0);
    @(negedge clk);
    start = 1'b0;
    chk("pulse.next_accepted", ready, 0);
    @(negedge clk);
    chk("pulse.next_done", done, 1);
    chk("pulse.next_result", $signed(result), 42);
    @(negedge clk);

    // reset in the middle of DIV iterations
    dones = done_cnt;
    start = 1'b1;
    op = OP_DIV;
    a = W'(-1000);
    b = W'(3);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.ready", ready, 1);
    chk("abort.result", result, 0);
    chk("abort.remainder", remainder, 0);
    repeat (14) @(negedge clk);
    chk("abort.no_done", done_cnt, dones);
    do_op("add_2_3", OP_ADD, 2, 3, 5, 0, 0, 0, 2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
